spi_seq: RTL and testbench

SPI_SEQ -- requirements
Module: spi_seq

---
 rtl/spi_seq_pkg.sv | 25 ++
 rtl/spi_seq_if.sv | 20 ++
 rtl/spi_rr_arb2.sv | 33 +++
 rtl/spi_seq.sv | 134 +++++++++++++
 tb/tb_spi_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared states, SPI register map and helpers for spi_seq
package spi_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_READ  = 3'd3;
  localparam state_t ST_NEXT  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Address 0 opens/closes a transaction (CS edge), address 1 streams data.
  localparam logic [2:0] SPI_ADDR_CTRL = 3'd0;
  localparam logic [2:0] SPI_ADDR_DATA = 3'd1;

  function automatic logic [7:0] port_byte(input logic [15:0] v, input logic sel);
    return sel ? v[15:8] : v[7:0];
  endfunction

  function automatic logic [1:0] port_dev(input logic [3:0] v, input logic sel);
    return sel ? v[3:2] : v[1:0];
  endfunction

endpackage

// File: rtl/spi_seq_if.sv
// rtl/spi_seq_if.sv - SPI peripheral register port owned by spi_seq
interface spi_seq_if;
  logic [1:0] spi_sel;
  logic [2:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_write;
  logic       spi_read;
  logic [7:0] spi_rdata;
  logic       spi_irq;

  modport master (
    output spi_sel, spi_addr, spi_wdata, spi_write, spi_read,
    input  spi_rdata, spi_irq
  );

  modport slave (
    input  spi_sel, spi_addr, spi_wdata, spi_write, spi_read,
    output spi_rdata, spi_irq
  );
endinterface

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-port round-robin arbiter with last-granted memory
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_port,
  output logic [1:0] grant
);

  logic last;

  // Port 1 counts as last-granted out of reset so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (upd_en) begin
      last <= upd_port;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (last) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/spi_seq.sv
// rtl/spi_seq.sv - two-port SPI transfer sequencer driving the SPI register port
module spi_seq
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [3:0]  dev,
  input  logic [15:0] len,
  output logic [1:0]  gnt,
  input  logic [15:0] tx_data,
  input  logic [1:0]  tx_valid,
  output logic [1:0]  tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [1:0]  done,
  output logic        busy,
  spi_seq_if.master   spi
);

  state_t     state;
  logic       gidx;
  logic [1:0] dev_r;
  logic [7:0] len_r;
  logic [7:0] remaining;
  logic [7:0] wdata_r;
  logic [2:0] addr_r;
  logic       write_r;
  logic [1:0] arb_gnt;
  logic       cur_valid;
  logic [7:0] cur_data;
  logic       tx_phase;

  spi_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .upd_en   (state == ST_DONE),
    .upd_port (gidx),
    .grant    (arb_gnt)
  );

  assign tx_phase  = (state == ST_START) || (state == ST_NEXT);
  assign cur_valid = gidx ? tx_valid[1] : tx_valid[0];
  assign cur_data  = port_byte(tx_data, gidx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt       <= 2'b00;
      gidx      <= 1'b0;
      dev_r     <= 2'd0;
      len_r     <= 8'd0;
      remaining <= 8'd0;
      wdata_r   <= 8'd0;
      addr_r    <= 3'd0;
      write_r   <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
    end else begin
      write_r  <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= arb_gnt;
            gidx  <= arb_gnt[1];
            dev_r <= port_dev(dev, arb_gnt[1]);
            len_r <= port_byte(len, arb_gnt[1]);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cur_valid) begin
            write_r   <= 1'b1;
            addr_r    <= SPI_ADDR_CTRL;
            wdata_r   <= cur_data;
            remaining <= len_r - 8'd1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The peripheral's flag still refers to the previous byte while the write is in flight.
          if (spi.spi_irq && !write_r) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          rx_data  <= spi.spi_rdata;
          rx_valid <= 1'b1;
          state    <= (remaining == 8'd0) ? ST_DONE : ST_NEXT;
        end
        ST_NEXT: begin
          if (cur_valid) begin
            write_r   <= 1'b1;
            addr_r    <= SPI_ADDR_DATA;
            wdata_r   <= cur_data;
            remaining <= remaining - 8'd1;
            state     <= ST_WAIT;
          end
        end
        ST_DONE: begin
          gnt     <= 2'b00;
          wdata_r <= 8'd0;
          addr_r  <= 3'd0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign tx_ready = tx_phase ? gnt : 2'b00;
  assign done     = (state == ST_DONE) ? gnt : 2'b00;

  // The final read goes to the control address, which closes the transaction.
  always_comb begin
    spi.spi_addr = 3'd0;
    if (state == ST_READ) begin
      spi.spi_addr = (remaining != 8'd0) ? SPI_ADDR_DATA : SPI_ADDR_CTRL;
    end else if (busy) begin
      spi.spi_addr = addr_r;
    end
  end

  assign spi.spi_sel   = busy ? dev_r : 2'd0;
  assign spi.spi_wdata = busy ? wdata_r : 8'd0;
  assign spi.spi_write = write_r;
  assign spi.spi_read  = (state == ST_READ);

endmodule

// File: tb/tb_spi_seq.sv
// tb/tb_spi_seq.sv - self-checking bench for spi_seq with an SPI peripheral model
module tb_spi_seq;

  localparam int LIM = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [3:0]  dev = 4'd0;
  logic [15:0] len = 16'd0;
  logic [15:0] tx_data = 16'd0;
  logic [1:0]  tx_valid = 2'b00;
  logic [1:0]  gnt, tx_ready, done;
  logic [7:0]  rx_data;
  logic        rx_valid, busy;

  spi_seq_if sif();

  spi_seq dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .dev      (dev),
    .len      (len),
    .gnt      (gnt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .done     (done),
    .busy     (busy),
    .spi      (sif)
  );

  always #5 clk = ~clk;

  // Peripheral model: irq rises irq_dly cycles after a write (0 = during the write cycle).
  logic       irq_m = 1'b0;
  logic [7:0] last_w = 8'd0;
  logic [7:0] resp_xor = 8'd0;
  int         irq_dly = 1;
  int         irq_cnt = 0;

  assign sif.spi_irq   = irq_m;
  assign sif.spi_rdata = (sif.spi_addr <= 3'd1) ? (last_w ^ resp_xor) : 8'h00;

  initial forever begin
    @(posedge clk); #1;
    if (reset) begin
      irq_m = 1'b0; irq_cnt = 0;
    end else if (sif.spi_write) begin
      last_w = sif.spi_wdata;
      if (irq_dly == 0) begin irq_m = 1'b1; irq_cnt = 0; end
      else begin irq_m = 1'b0; irq_cnt = irq_dly; end
    end else if (sif.spi_read) begin
      irq_m = 1'b0;
    end else if (irq_cnt > 0) begin
      irq_cnt--;
      if (irq_cnt == 0) irq_m = 1'b1;
    end
  end

  // Monitor
  logic [12:0] wr_q[$];
  logic [2:0]  rd_q[$];
  logic [7:0]  rx_q[$];
  logic        gord[$];
  int ndone0 = 0, ndone1 = 0, excl_bad = 0, idle_bad = 0, lat_bad = 0;
  int cyc = 0, acc_cyc = -10, wr_cyc = -10, rise_cyc = -10;
  logic irq_prev = 1'b0;
  logic [1:0] gnt_prev = 2'b00;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (sif.spi_write && sif.spi_read) excl_bad++;
      if (!busy && (sif.spi_sel != 0 || sif.spi_addr != 0 || sif.spi_wdata != 0)) idle_bad++;
      if (sif.spi_write) begin
        wr_q.push_back({sif.spi_sel, sif.spi_addr, sif.spi_wdata});
        if (cyc != acc_cyc + 1) lat_bad++;
        wr_cyc = cyc;
      end
      if (sif.spi_irq && !irq_prev) rise_cyc = cyc;
      if (sif.spi_read) begin
        rd_q.push_back(sif.spi_addr);
        if (cyc != ((rise_cyc == wr_cyc) ? wr_cyc + 2 : rise_cyc + 1)) lat_bad++;
      end
      if (rx_valid) rx_q.push_back(rx_data);
      if (done[0]) ndone0++;
      if (done[1]) ndone1++;
      if ((tx_valid & tx_ready) != 2'b00) acc_cyc = cyc;
      if (gnt != 2'b00 && gnt_prev == 2'b00) gord.push_back(gnt[1]);
    end
    irq_prev = sif.spi_irq;
    gnt_prev = gnt;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic do_xfer(input int p, input logic [1:0] d, input logic [7:0] l,
                         input logic [7:0] base, input logic [7:0] step,
                         input int stall_at, input int stall_n);
    int t, nbytes, w0, r0, d0;
    d0 = (p == 0) ? ndone0 : ndone1;
    dev[p*2 +: 2] = d;
    len[p*8 +: 8] = l;
    req[p] = 1'b1;
    t = 0;
    while (!gnt[p] && t < LIM) begin cyc1(); t++; end
    req[p] = 1'b0;
    if (!gnt[p]) begin check("grant timeout", 0, 1); return; end
    nbytes = (l == 8'd0) ? 256 : int'(l);
    for (int i = 0; i < nbytes; i++) begin
      t = 0;
      while (!tx_ready[p] && t < LIM) begin cyc1(); t++; end
      if (!tx_ready[p]) begin check("tx_ready timeout", 0, 1); return; end
      if (i == stall_at) begin
        w0 = wr_q.size(); r0 = rd_q.size();
        repeat (stall_n) @(posedge clk);
        #1;
        check("stall writes", wr_q.size() - w0, 0);
        check("stall reads", rd_q.size() - r0, 0);
        check("stall tx_ready", tx_ready, 2'b01 << p);
      end
      tx_data[p*8 +: 8] = 8'(base + 8'(i) * step);
      tx_valid[p] = 1'b1;
      cyc1();
      tx_valid[p] = 1'b0;
    end
    t = 0;
    while (((p == 0) ? ndone0 : ndone1) == d0 && t < LIM) begin cyc1(); t++; end
    if (((p == 0) ? ndone0 : ndone1) == d0) check("done timeout", 0, 1);
    cyc1();
  endtask

  typedef struct {
    int         port;
    logic [1:0] dev;
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] rxor;
    int         dly;
    int         stall_at;
    int         stall_n;
    int         n;
    logic [7:0] last_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx);
    vec_t v;
    int w0, r0, x0, d00, d10, bad;
    logic [7:0] b;
    v = vecs[idx];
    resp_xor = v.rxor;
    irq_dly  = v.dly;
    w0 = wr_q.size(); r0 = rd_q.size(); x0 = rx_q.size();
    d00 = ndone0; d10 = ndone1;
    do_xfer(v.port, v.dev, v.len, v.base, v.step, v.stall_at, v.stall_n);
    check($sformatf("v%0d writes", idx), wr_q.size() - w0, v.n);
    check($sformatf("v%0d reads", idx), rd_q.size() - r0, v.n);
    check($sformatf("v%0d rx_valid", idx), rx_q.size() - x0, v.n);
    check($sformatf("v%0d done0", idx), ndone0 - d00, (v.port == 0) ? 1 : 0);
    check($sformatf("v%0d done1", idx), ndone1 - d10, (v.port == 1) ? 1 : 0);
    if (rx_q.size() - x0 == v.n && wr_q.size() - w0 == v.n && rd_q.size() - r0 == v.n) begin
      bad = 0;
      for (int k = 0; k < v.n; k++) begin
        b = 8'(v.base + 8'(k) * v.step);
        if (wr_q[w0+k] !== {v.dev, (k == 0) ? 3'd0 : 3'd1, b}) bad++;
        if (rd_q[r0+k] !== ((k == v.n - 1) ? 3'd0 : 3'd1)) bad++;
        if (rx_q[x0+k] !== (b ^ v.rxor)) bad++;
      end
      check($sformatf("v%0d sequence errors", idx), bad, 0);
      check($sformatf("v%0d last rx_data", idx), rx_q[rx_q.size()-1], v.last_rx);
    end
  endtask

  initial begin
    int g0, d00, d10, t;
    //          port dev   len    base   step   xor    dly stall n    last_rx
    vecs[0] = '{0, 2'd1, 8'd1, 8'hA5, 8'h00, 8'h99, 2, -1, 0, 1,   8'h3C};
    vecs[1] = '{1, 2'd2, 8'd3, 8'h11, 8'h11, 8'h00, 1, -1, 0, 3,   8'h33};
    vecs[2] = '{0, 2'd3, 8'd2, 8'h80, 8'h01, 8'hFF, 0, -1, 0, 2,   8'h7E};
    vecs[3] = '{1, 2'd0, 8'd0, 8'h00, 8'h01, 8'h5A, 1, -1, 0, 256, 8'hA5};
    vecs[4] = '{0, 2'd1, 8'd3, 8'h40, 8'h01, 8'h00, 3, 1, 10, 3,   8'h42};

    repeat (3) cyc1();
    check("reset gnt", gnt, 2'b00);
    check("reset tx_ready", tx_ready, 2'b00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset done", done, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset spi strobes", {sif.spi_write, sif.spi_read}, 2'b00);
    check("reset rx_data", rx_data, 8'h00);
    check("reset spi bus", {sif.spi_sel, sif.spi_addr, sif.spi_wdata}, 13'd0);
    reset = 1'b0;
    cyc1();

    // Simultaneous requests: port 0 first out of reset, alternating afterwards.
    irq_dly = 1; resp_xor = 8'h00;
    for (int r = 0; r < 2; r++) begin
      g0 = gord.size(); d00 = ndone0; d10 = ndone1;
      fork
        do_xfer(0, 2'd1, 8'd1, 8'h10, 8'h00, -1, 0);
        do_xfer(1, 2'd2, 8'd1, 8'h20, 8'h00, -1, 0);
      join
      check($sformatf("pair%0d grants", r), gord.size() - g0, 2);
      if (gord.size() - g0 == 2) begin
        check($sformatf("pair%0d first grant", r), gord[g0], 1'b0);
        check($sformatf("pair%0d second grant", r), gord[g0+1], 1'b1);
      end
      check($sformatf("pair%0d done pulses", r), (ndone0 - d00) * 16 + (ndone1 - d10), 17);
    end

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset while waiting on the peripheral aborts without a done pulse.
    irq_dly = 30; resp_xor = 8'h00;
    d00 = ndone0;
    dev[1:0] = 2'd1; len[7:0] = 8'd2; req[0] = 1'b1;
    t = 0;
    while (!gnt[0] && t < LIM) begin cyc1(); t++; end
    req[0] = 1'b0;
    t = 0;
    while (!tx_ready[0] && t < LIM) begin cyc1(); t++; end
    tx_data[7:0] = 8'h77; tx_valid[0] = 1'b1;
    cyc1();
    tx_valid[0] = 1'b0;
    repeat (3) cyc1();
    check("wait-state busy", busy, 1'b1);
    reset = 1'b1;
    cyc1();
    check("abort busy", busy, 1'b0);
    check("abort gnt", gnt, 2'b00);
    cyc1();
    reset = 1'b0;
    repeat (5) cyc1();
    check("abort done pulses", ndone0 - d00, 0);
    run_vec(0);

    check("write/read overlap", excl_bad, 0);
    check("idle bus nonzero", idle_bad, 0);
    check("strobe latency", lat_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
